// File: rtl/bop_it_game_ctrl.sv
// Bop-It game controller: issues pseudo-random action commands, times the
// player's response, keeps the score and shrinks the window as play goes on.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - debounced start button (level, rising edge used)
//   btn[2:0]   - debounced action buttons, btn[i] answers command i
//   command    - 00/01/10 action, 11 game over (registered)
//   score      - 0..99 binary score (registered)
//   game_over  - high in OVER (registered)
//   busy       - high in ISSUE, WAIT and GAP (registered)
module bop_it_game_ctrl #(
  parameter int         WINDOW_INIT = 100000000,
  parameter int         WINDOW_STEP = 10000000,
  parameter int         WINDOW_MIN  = 30000000,
  parameter int         GAP_CYCLES  = 25000000,
  parameter int         CW          = 27,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] btn,
  output logic [1:0] command,
  output logic [6:0] score,
  output logic       game_over,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, GAP, OVER
  } state_t;

  localparam logic [CW-1:0] W_INIT = CW'(WINDOW_INIT);
  localparam logic [CW-1:0] W_STEP = CW'(WINDOW_STEP);
  localparam logic [CW-1:0] W_MIN  = CW'(WINDOW_MIN);
  localparam logic [CW-1:0] W_THR  = CW'(WINDOW_MIN + WINDOW_STEP);
  localparam logic [CW-1:0] G_LEN  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] T_ONE  = CW'(1);

  state_t        state, state_n;
  logic [7:0]    lfsr;
  logic [2:0]    btn_q;
  logic          start_q;
  logic [2:0]    btn_rise;
  logic          start_rise;
  logic [CW-1:0] timer;
  logic [CW-1:0] window;
  logic [CW-1:0] window_dec;
  logic [1:0]    cmd_q, cmd_n;
  logic [2:0]    want;
  logic          hit, miss, last, milestone, t_end;
  logic [6:0]    score_inc;
  logic [1:0]    command_d;
  logic          game_over_d, busy_d;

  assign btn_rise   = btn & ~btn_q;
  assign start_rise = start & ~start_q;
  assign want       = 3'b001 << cmd_q;
  // Any edge outside the commanded button loses, even alongside a good one.
  assign miss       = |(btn_rise & ~want);
  assign hit        = (btn_rise == want);
  assign score_inc  = score + 7'd1;
  assign last       = (score_inc == 7'd99);
  assign milestone  = ((score_inc % 7'd10) == 7'd0);
  assign t_end      = (timer == T_ONE);
  // Clamp to the floor without ever wrapping below zero.
  assign window_dec = (window >= W_THR) ? window - W_STEP : W_MIN;
  assign cmd_n      = (state == ISSUE) ? 2'(lfsr % 8'd3) : cmd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_rise) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (miss)       state_n = OVER;
        else if (hit)   state_n = last ? OVER : GAP;
        else if (t_end) state_n = OVER;
      end
      GAP:   if (t_end) state_n = ISSUE;
      OVER:  if (start_rise) state_n = ISSUE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    game_over_d = (state_n == OVER);
    busy_d      = (state_n == ISSUE) ||
                  (state_n == WAIT) ||
                  (state_n == GAP);
    unique case (state_n)
      IDLE:    command_d = 2'b00;
      OVER:    command_d = 2'b11;
      default: command_d = cmd_n;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      command   <= 2'b00;
      game_over <= 1'b0;
      busy      <= 1'b0;
    end else begin
      command   <= command_d;
      game_over <= game_over_d;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= LFSR_SEED;
      btn_q   <= 3'b000;
      start_q <= 1'b0;
      score   <= 7'd0;
      window  <= W_INIT;
      timer   <= '0;
      cmd_q   <= 2'b00;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      btn_q   <= btn;
      start_q <= start;
      cmd_q   <= cmd_n;
      unique case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            score  <= 7'd0;
            window <= W_INIT;
          end
        end
        ISSUE: timer <= window;
        WAIT: begin
          if (miss) begin
            timer <= timer;
          end else if (hit) begin
            score <= score_inc;
            if (milestone) window <= window_dec;
            timer <= G_LEN;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        GAP: timer <= timer - T_ONE;
        default: timer <= timer;
      endcase
    end
  end

endmodule
